fifo_wr_arbiter: RTL

- Round-robin arbiter that shares the single write port of the fifo block among NUM_REQ requesters.
- Each requester presents req plus a data word, and receives a one-cycle ack when its word is written.
- The arbiter drives the fifo wr_en/data_in and throttles on full.
- Each grant is a burst of at most MAX_BURST words, so one requester cannot starve the others.

---
 rtl/fifo_arb_pkg.sv | 14 +
 rtl/fifo_rr_pick.sv | 28 ++
 rtl/fifo_wr_arbiter.sv | 114 +++++++++++
 3 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared types and defaults for the fifo write-port arbiter.
// Optional stall statistics are enabled with FIFO_WR_ARB_STATS_EN.
package fifo_arb_pkg;

  typedef enum logic {
    ARB_IDLE,
    ARB_BURST
  } arb_state_t;

  localparam int ARB_NUM_REQ   = 4;
  localparam int ARB_MAX_BURST = 4;
  localparam int STALL_CNT_W   = 16;

endpackage

// File: rtl/fifo_rr_pick.sv
// Combinational round-robin picker: first set req bit at or
// after rr_ptr, wrapping modulo NUM_REQ.
module fifo_rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic               found,
  output logic [IDX_W-1:0]   idx
);

  always_comb begin
    found = 1'b0;
    idx   = rr_ptr;
    // Scan from the far end so the closest candidate wins.
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      int j;
      j = int'(rr_ptr) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (req[j]) begin
        found = 1'b1;
        idx   = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter for the fifo write port.
// Define FIFO_WR_ARB_STATS_EN to add the stall_cnt output.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ    = ARB_NUM_REQ,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = ARB_MAX_BURST,
  localparam int IDX_W     = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            ack,
  input  logic                          full,
  output logic                          wr_en,
  output logic [DATA_WIDTH-1:0]         data_in,
  output logic                          busy,
  output logic [IDX_W-1:0]              owner
`ifdef FIFO_WR_ARB_STATS_EN
  ,
  output logic [STALL_CNT_W-1:0]        stall_cnt
`endif
);

  localparam int BEAT_W = $clog2(MAX_BURST + 1);

  arb_state_t         state, state_n;
  logic [IDX_W-1:0]   rr_ptr, ptr_n;
  logic [IDX_W-1:0]   owner_n;
  logic [BEAT_W-1:0]  beat_cnt, beat_n;
  logic               found;
  logic [IDX_W-1:0]   pick;
  logic               rel;
  logic [IDX_W-1:0]   owner_inc;

  fifo_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req    (req),
    .rr_ptr (rr_ptr),
    .found  (found),
    .idx    (pick)
  );

  assign owner_inc = (owner == IDX_W'(NUM_REQ - 1))
                   ? '0 : owner + 1'b1;

  assign busy    = (state == ARB_BURST);
  assign data_in = req_data[owner*DATA_WIDTH +: DATA_WIDTH];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ARB_IDLE;
      rr_ptr   <= '0;
      owner    <= '0;
      beat_cnt <= '0;
    end else begin
      state    <= state_n;
      rr_ptr   <= ptr_n;
      owner    <= owner_n;
      beat_cnt <= beat_n;
    end
  end

  always_comb begin
    state_n = state;
    ptr_n   = rr_ptr;
    owner_n = owner;
    beat_n  = beat_cnt;
    wr_en   = 1'b0;
    rel     = 1'b0;
    ack     = '0;
    unique case (state)
      ARB_IDLE: begin
        if (found) begin
          owner_n = pick;
          beat_n  = '0;
          state_n = ARB_BURST;
        end
      end
      ARB_BURST: begin
        wr_en = req[owner] & ~full;
        // A dropped request wins over full.
        if (!req[owner]) begin
          rel = 1'b1;
        end else if (wr_en) begin
          beat_n = beat_cnt + 1'b1;
          if (beat_n == BEAT_W'(MAX_BURST)) rel = 1'b1;
        end
        if (rel) begin
          state_n = ARB_IDLE;
          ptr_n   = owner_inc;
        end
      end
      default: ;
    endcase
    ack[owner] = wr_en;
  end

`ifdef FIFO_WR_ARB_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
    end else if (busy && req[owner] && full
                 && stall_cnt != '1) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end
`endif

endmodule
